sp_shared_unit_arbiter: RTL

Round-robin arbiter that shares one multi-cycle ScalaPipe arithmetic unit among N requesters. Targets units with the (clk, rst, a, b, result, ready) contract, e.g. sp_divF32, sp_sqrtF32 or sp_divS. A start pulse on the unit's rst launches an operation, and ready rises when the result is valid. The block sits between kernel datapaths and a single expensive unit instance, and serialises their operations onto it.

---
 rtl/sp_shared_unit_arbiter_pkg.sv | 23 ++
 rtl/sp_rr_pick.sv | 25 ++
 rtl/sp_shared_unit_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sp_shared_unit_arbiter_pkg.sv
// Shared definitions for the shared-unit arbiter: FSM state encoding and operand-slice macro.
// Latency: none (types and macros only).
// Backpressure: not applicable.
`ifndef SP_SHARED_UNIT_ARBITER_PKG_SV
`define SP_SHARED_UNIT_ARBITER_PKG_SV

// Selects slice idx of width w from a packed bus of concatenated operands.
`ifndef SP_SLICE
`define SP_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package sp_shared_unit_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_e;

endpackage

`endif

// File: rtl/sp_rr_pick.sv
// Combinational round-robin picker: first requester at or after pointer p, wrapping.
// Latency: zero cycles (pure combinational).
// Backpressure: none; any is low when no request is present and g is then 0.
module sp_rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] p,
    output logic          any,
    output logic [PW-1:0] g
);

    // Scan from the farthest position back toward p so the nearest hit wins.
    always_comb begin
        any = |req;
        g   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(p) + k) % N]) begin
                g = PW'((int'(p) + k) % N);
            end
        end
    end

endmodule

// File: rtl/sp_shared_unit_arbiter.sv
// Round-robin sharing of one multi-cycle arithmetic unit among N requesters.
// Latency: unit latency L plus 3 cycles (request seen in IDLE -> ack in cycle 2+L).
// Backpressure: requesters hold req/operands until their one-cycle ack; others wait in IDLE.
`ifndef SP_SLICE
`define SP_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

module sp_shared_unit_arbiter
    import sp_shared_unit_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   a_in,
    input  logic [N*WIDTH-1:0]   b_in,
    output logic [N-1:0]         ack,
    output logic [WIDTH-1:0]     result,
    output logic [N-1:0]         grant,
    output logic                 busy,
    output logic                 unit_start,
    output logic [WIDTH-1:0]     unit_a,
    output logic [WIDTH-1:0]     unit_b,
    input  logic [WIDTH-1:0]     unit_result,
    input  logic                 unit_ready
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    arb_state_e       state_q, state_d;
    logic [PW-1:0]    p_q, p_d;
    logic [PW-1:0]    g_q, g_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] unit_a_q, unit_a_d;
    logic [WIDTH-1:0] unit_b_q, unit_b_d;

    logic             pick_any;
    logic [PW-1:0]    pick_g;

    sp_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req (req),
        .p   (p_q),
        .any (pick_any),
        .g   (pick_g)
    );

    // Next-state logic: arbitrate in IDLE, pulse start, wait for the unit, acknowledge.
    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        g_d      = g_q;
        grant_d  = grant_q;
        result_d = result_q;
        unit_a_d = unit_a_q;
        unit_b_d = unit_b_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    g_d      = pick_g;
                    grant_d  = {{(N-1){1'b0}}, 1'b1} << pick_g;
                    unit_a_d = `SP_SLICE(a_in, int'(pick_g), WIDTH);
                    unit_b_d = `SP_SLICE(b_in, int'(pick_g), WIDTH);
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (unit_ready) begin
                    result_d = unit_result;
                    // The requester just served drops to lowest priority.
                    p_d      = (g_q == PW'(N - 1)) ? '0 : g_q + PW'(1);
                    state_d  = ST_ACK;
                end
            end
            ST_ACK: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight operation without ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            p_q      <= '0;
            g_q      <= '0;
            grant_q  <= '0;
            result_q <= '0;
            unit_a_q <= '0;
            unit_b_q <= '0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            g_q      <= g_d;
            grant_q  <= grant_d;
            result_q <= result_d;
            unit_a_q <= unit_a_d;
            unit_b_q <= unit_b_d;
        end
    end

    // Outputs are registers or state decodes; rst is ORed into start to abort the unit.
    always_comb begin
        ack        = (state_q == ST_ACK) ? grant_q : '0;
        grant      = grant_q;
        busy       = (state_q != ST_IDLE);
        unit_start = (state_q == ST_START) | rst;
        result     = result_q;
        unit_a     = unit_a_q;
        unit_b     = unit_b_q;
    end

endmodule
